// File: rtl/rx_4b5b_decode_9600_pkg.sv
// ============================================================================
// rx_4b5b_decode_9600_pkg
// Shared 4b5b line-code constants, decode function, FSM state types, baud defaults.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rx_4b5b_decode_9600_pkg;

    localparam int DEF_CLKS_PER_BIT_RX = 4340;
    localparam int DEF_CLKS_PER_BIT_TX = 5208;
    localparam int DEF_FIFO_DEPTH      = 2;

    localparam logic [4:0] CODE_0 = 5'b11110;
    localparam logic [4:0] CODE_1 = 5'b01001;
    localparam logic [4:0] CODE_2 = 5'b10100;
    localparam logic [4:0] CODE_3 = 5'b10101;
    localparam logic [4:0] CODE_4 = 5'b01010;
    localparam logic [4:0] CODE_5 = 5'b01011;
    localparam logic [4:0] CODE_6 = 5'b01110;
    localparam logic [4:0] CODE_7 = 5'b01111;
    localparam logic [4:0] CODE_8 = 5'b10010;
    localparam logic [4:0] CODE_9 = 5'b10011;
    localparam logic [4:0] CODE_A = 5'b10110;
    localparam logic [4:0] CODE_B = 5'b10111;
    localparam logic [4:0] CODE_C = 5'b11010;
    localparam logic [4:0] CODE_D = 5'b11011;
    localparam logic [4:0] CODE_E = 5'b11100;
    localparam logic [4:0] CODE_F = 5'b11101;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Returns {valid, nibble}; valid=0 for any code outside the table.
    function automatic logic [4:0] dec5b4b(input logic [4:0] code);
        logic [4:0] res;
        res = 5'b0_0000;
        case (code)
            CODE_0:  res = {1'b1, 4'h0};
            CODE_1:  res = {1'b1, 4'h1};
            CODE_2:  res = {1'b1, 4'h2};
            CODE_3:  res = {1'b1, 4'h3};
            CODE_4:  res = {1'b1, 4'h4};
            CODE_5:  res = {1'b1, 4'h5};
            CODE_6:  res = {1'b1, 4'h6};
            CODE_7:  res = {1'b1, 4'h7};
            CODE_8:  res = {1'b1, 4'h8};
            CODE_9:  res = {1'b1, 4'h9};
            CODE_A:  res = {1'b1, 4'hA};
            CODE_B:  res = {1'b1, 4'hB};
            CODE_C:  res = {1'b1, 4'hC};
            CODE_D:  res = {1'b1, 4'hD};
            CODE_E:  res = {1'b1, 4'hE};
            CODE_F:  res = {1'b1, 4'hF};
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_8n1.sv
// ============================================================================
// uart_tx_8n1
// 8N1 serial transmitter; accepts a new byte during the last stop-bit clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_8n1
    import rx_4b5b_decode_9600_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT_TX
) (
    input  logic       CLK_50M,
    input  logic       RST,
    input  logic [7:0] data,
    input  logic       start,
    output logic       busy,
    output logic       txd
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t      state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [2:0]     bit_idx, bit_idx_next;
    logic [7:0]     shreg, shreg_next;
    logic           bit_end;

    assign bit_end = (cnt == BIT_LAST);

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        case (state)
            TX_IDLE: begin
                cnt_next = '0;
                if (start) begin
                    state_next = TX_START;
                    shreg_next = data;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_next     = '0;
                    shreg_next   = {1'b0, shreg[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    // Chain straight into the next start bit so bursts have no gap.
                    if (start) begin
                        state_next = TX_START;
                        shreg_next = data;
                    end else begin
                        state_next = TX_IDLE;
                    end
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    assign busy = !((state == TX_IDLE) || ((state == TX_STOP) && bit_end));

    always_comb begin
        txd = 1'b1;
        case (state)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = shreg[0];
            default:  txd = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rx_4b5b_decode_9600.sv
// ============================================================================
// rx_4b5b_decode_9600
// Receives 4b5b-coded frames, decodes to bytes, re-sends them as 8N1 through a small FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rx_4b5b_decode_9600
    import rx_4b5b_decode_9600_pkg::*;
#(
    parameter int CLKS_PER_BIT_RX = DEF_CLKS_PER_BIT_RX,
    parameter int CLKS_PER_BIT_TX = DEF_CLKS_PER_BIT_TX,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic       CLK_50M,
    input  logic       RST,
    input  logic       RS232_DCE_RXD,
    output logic       RS232_DTE_TXD,
    output logic [7:0] LED,
    output logic [2:0] ERR
);

    localparam int               RXCW     = $clog2(CLKS_PER_BIT_RX);
    localparam logic [RXCW-1:0]  RX_LAST  = RXCW'(CLKS_PER_BIT_RX - 1);
    localparam logic [RXCW-1:0]  RX_HALF  = RXCW'(CLKS_PER_BIT_RX / 2 - 1);
    localparam int               PTRW     = $clog2(FIFO_DEPTH);
    localparam int               CNTW     = PTRW + 1;
    localparam logic [CNTW-1:0]  FIFO_FULL = CNTW'(FIFO_DEPTH);

    // ---------------- input synchronizer ----------------
    logic sync_meta, sync_line, line_d;

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
            line_d    <= 1'b1;
        end else begin
            sync_meta <= RS232_DCE_RXD;
            sync_line <= sync_meta;
            line_d    <= sync_line;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t        rx_state, rx_next;
    logic [RXCW-1:0]  rx_cnt, rx_cnt_next;
    logic [3:0]       bit_cnt, bit_cnt_next;
    logic [9:0]       code, code_next;
    logic             wait_high, wait_high_next;
    logic             push_next, code_err, frame_err;
    logic             push_vld;
    logic [7:0]       push_byte;
    logic [4:0]       dec_lo, dec_hi;

    assign dec_lo = dec5b4b(code[4:0]);
    assign dec_hi = dec5b4b(code[9:5]);

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            bit_cnt   <= '0;
            code      <= '0;
            wait_high <= 1'b0;
            push_vld  <= 1'b0;
            push_byte <= '0;
        end else begin
            rx_state  <= rx_next;
            rx_cnt    <= rx_cnt_next;
            bit_cnt   <= bit_cnt_next;
            code      <= code_next;
            wait_high <= wait_high_next;
            push_vld  <= push_next;
            push_byte <= {dec_hi[3:0], dec_lo[3:0]};
        end
    end

    always_comb begin
        rx_next        = rx_state;
        rx_cnt_next    = rx_cnt + 1'b1;
        bit_cnt_next   = bit_cnt;
        code_next      = code;
        wait_high_next = wait_high;
        push_next      = 1'b0;
        code_err       = 1'b0;
        frame_err      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_next    = '0;
                wait_high_next = 1'b0;
                if (line_d && !sync_line) begin
                    rx_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == RX_HALF) begin
                    rx_cnt_next  = '0;
                    bit_cnt_next = '0;
                    rx_next      = sync_line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == RX_LAST) begin
                    rx_cnt_next  = '0;
                    code_next    = {sync_line, code[9:1]};
                    bit_cnt_next = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        rx_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (wait_high) begin
                    rx_cnt_next = '0;
                    if (sync_line) begin
                        rx_next = RX_IDLE;
                    end
                end else if (rx_cnt == RX_LAST) begin
                    rx_cnt_next = '0;
                    if (sync_line) begin
                        rx_next = RX_IDLE;
                        if (dec_lo[4] && dec_hi[4]) begin
                            push_next = 1'b1;
                        end else begin
                            code_err = 1'b1;
                        end
                    end else begin
                        // Bad stop bit: park here until the line idles high again.
                        frame_err      = 1'b1;
                        wait_high_next = 1'b1;
                    end
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // ---------------- byte FIFO ----------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTRW-1:0]  wr_ptr, rd_ptr;
    logic [CNTW-1:0]  fifo_cnt;
    logic             tx_busy, pop, push_ok, overflow;

    assign pop      = !tx_busy && (fifo_cnt != '0);
    assign push_ok  = push_vld && ((fifo_cnt != FIFO_FULL) || pop);
    assign overflow = push_vld && !push_ok;

    always_ff @(posedge CLK_50M) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_byte;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---------------- status ----------------
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            LED <= 8'h00;
            ERR <= 3'b000;
        end else begin
            if (push_vld) begin
                LED <= push_byte;
            end
            ERR <= ERR | {overflow, frame_err, code_err};
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT_TX)
    ) u_tx (
        .CLK_50M (CLK_50M),
        .RST     (RST),
        .data    (fifo_mem[rd_ptr]),
        .start   (pop),
        .busy    (tx_busy),
        .txd     (RS232_DTE_TXD)
    );

endmodule

`default_nettype wire

// File: tb/tb_rx_4b5b_decode_9600.sv
// ============================================================================
// tb_rx_4b5b_decode_9600
// Scoreboard bench: driver encodes frames, model predicts bytes/LED/ERR, monitor decodes TXD.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rx_4b5b_decode_9600;

    localparam int RX = 8;
    localparam int TX = 40;
    localparam int DEPTH = 2;
    localparam logic [4:0] ENC [16] = '{
        5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
        5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       txd;
    logic [7:0] led;
    logic [2:0] err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rst_count = 0;
    int frames_seen = 0;

    logic [7:0] exp_q [$];
    int         exp_t_q [$];
    int         sched_q [$];
    logic [7:0] led_m = 8'h00;
    logic [2:0] err_m = 3'b000;

    rx_4b5b_decode_9600 #(
        .CLKS_PER_BIT_RX (RX),
        .CLKS_PER_BIT_TX (TX),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .CLK_50M       (clk),
        .RST           (rst),
        .RS232_DCE_RXD (rxd),
        .RS232_DTE_TXD (txd),
        .LED           (led),
        .ERR           (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_count <= rst_count + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic int dec_nib(input logic [4:0] c);
        for (int i = 0; i < 16; i++) if (ENC[i] == c) return i;
        return -1;
    endfunction

    function automatic logic [9:0] enc_byte(input logic [7:0] b);
        return {ENC[b[7:4]], ENC[b[3:0]]};
    endfunction

    // Reference: decode per the code table, schedule TX at 10 bit times per byte,
    // and count bytes still waiting in the FIFO when a new one arrives.
    task automatic model_frame(input logic [9:0] c, input logic stop, input int k);
        int tp, lo, hi, waiting, st;
        tp = k + 11 * RX + RX / 2 + 2;
        if (!stop) begin
            err_m[1] = 1'b1;
            return;
        end
        lo = dec_nib(c[4:0]);
        hi = dec_nib(c[9:5]);
        if (lo < 0 || hi < 0) begin
            err_m[0] = 1'b1;
            return;
        end
        led_m = 8'(hi * 16 + lo);
        waiting = 0;
        foreach (sched_q[i]) if (sched_q[i] - 1 > tp) waiting++;
        if (waiting >= DEPTH) begin
            err_m[2] = 1'b1;
            return;
        end
        st = tp + 2;
        if (sched_q.size() != 0 && sched_q[$] + 10 * TX > st) st = sched_q[$] + 10 * TX;
        sched_q.push_back(st);
        exp_q.push_back(led_m);
        exp_t_q.push_back(st);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_t_q.delete();
        sched_q.delete();
        led_m = 8'h00;
        err_m = 3'b000;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (RX) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [9:0] c, input logic stop);
        int k;
        k = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 10; i++) drive_bit(c[i]);
        drive_bit(stop);
        rxd = 1'b1;
        model_frame(c, stop, k);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d bytes still expected, expected 0", exp_q.size());
            exp_q.delete();
            exp_t_q.delete();
        end
        repeat (TX) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_led"}, 32'(led), 32'(led_m));
        check({tag, "_err"}, 32'(err), 32'(err_m));
    endtask

    // Monitor: decodes every 8N1 frame on TXD and scores it against the queue.
    initial begin
        logic       prev;
        logic [7:0] b, eb;
        logic       s0, s1;
        int         fc, rc, et;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !txd) begin
                fc = cyc;
                rc = rst_count;
                frames_seen++;
                repeat (TX / 2) @(negedge clk);
                s0 = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (TX) @(negedge clk);
                    b[i] = txd;
                end
                repeat (TX) @(negedge clk);
                s1 = txd;
                if (rc == rst_count && !rst) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL tx_unexpected: got byte %0h, expected no output", b);
                    end else begin
                        eb = exp_q.pop_front();
                        et = exp_t_q.pop_front();
                        check("tx_byte", 32'(b), 32'(eb));
                        check("tx_start_stop", 32'({s0, s1}), 32'b01);
                        tests++;
                        if (fc < et - 2 || fc > et + 2) begin
                            fails++;
                            $display("FAIL tx_latency: start at cycle %0d, expected %0d", fc, et);
                        end
                    end
                end
            end
            prev = txd;
        end
    end

    initial begin
        int n, seen;
        logic [9:0] c;
        logic [7:0] rb;
        int kind;

        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_led", 32'(led), 32'h00);
        check("reset_err", 32'(err), 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 0x00 with literal line code, then 0xA5
        send_frame(10'b11110_11110, 1'b1);
        wait_drain(2000);
        check("t1_led", 32'(led), 32'h00);
        check("t1_err", 32'(err), 32'h0);
        send_frame({5'b10110, 5'b01011}, 1'b1);
        wait_drain(2000);
        check("t2_led", 32'(led), 32'hA5);
        check_status("t2");

        // invalid low code, then a good 0x3C
        send_frame({ENC[4'h7], 5'b00000}, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("t3_err", 32'(err), 32'b001);
        check("t3_led_kept", 32'(led), 32'hA5);
        send_frame(enc_byte(8'h3C), 1'b1);
        wait_drain(2000);
        check_status("t3b");

        // framing error, then 0x81
        do_reset();
        send_frame(enc_byte(8'h99), 1'b0);
        repeat (RX) @(posedge clk);
        #1;
        check("t4_err", 32'(err), 32'b010);
        send_frame(enc_byte(8'h81), 1'b1);
        wait_drain(2000);
        check_status("t4b");

        // back-to-back burst into a slow transmitter
        do_reset();
        send_frame(enc_byte(8'h11), 1'b1);
        send_frame(enc_byte(8'h22), 1'b1);
        send_frame(enc_byte(8'h33), 1'b1);
        send_frame(enc_byte(8'h44), 1'b1);
        check("t5_queued", 32'(exp_q.size()), 32'd3);
        wait_drain(4000);
        check("t5_err", 32'(err), 32'b100);
        check_status("t5");

        // short glitch on idle line
        do_reset();
        seen = frames_seen;
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (20 * RX) @(posedge clk);
        #1;
        check("t6_glitch_err", 32'(err), 32'h0);
        check("t6_glitch_tx", 32'(frames_seen), 32'(seen));

        // reset while transmitting 0x5A
        send_frame(enc_byte(8'h5A), 1'b1);
        n = 0;
        while (txd !== 1'b0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("t6_tx_started", 32'(txd), 32'd0);
        repeat (3 * TX + TX / 2) @(posedge clk);
        #1;
        check("t6_bit2_low", 32'(txd), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_txd", 32'(txd), 32'd1);
        check("t6_rst_led", 32'(led), 32'h00);
        rst = 1'b0;
        model_reset();
        seen = frames_seen;
        repeat (12 * TX) @(posedge clk);
        #1;
        check("t6_fifo_empty", 32'(frames_seen), 32'(seen));
        check_status("t6");

        // randomized frames: good bytes, random codes, bad stop bits
        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 9);
            rb = 8'($urandom);
            if (kind < 6) begin
                send_frame(enc_byte(rb), 1'b1);
            end else begin
                c = 10'($urandom);
                send_frame(c, (kind < 9) ? 1'b1 : 1'b0);
            end
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1;
            wait_drain(2000);
            check_status("rand");
        end

        wait_drain(2000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
